// File: rtl/paddle_ctrl_pkg.sv
// rtl/paddle_ctrl_pkg.sv - paddle FSM encodings and court limit constants
package paddle_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Court limits shared with the ball and collision blocks
    localparam int COURT_POS_MIN  = 0;
    localparam int COURT_POS_MAX  = 400;
    localparam int COURT_POS_INIT = 200;

endpackage

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - paddle position with press step, hold auto-repeat, clamp and recentre
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int POS_W        = 10,
    parameter int POS_MIN      = COURT_POS_MIN,
    parameter int POS_MAX      = COURT_POS_MAX,
    parameter int POS_INIT     = COURT_POS_INIT,
    parameter int STEP         = 4,
    parameter int CNT_W        = 25,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 2_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             enable,
    input  logic             center,
    output logic [POS_W-1:0] paddle_pos,
    output logic             move_pulse,
    output logic             at_top,
    output logic             at_bottom
);

    localparam logic [POS_W-1:0] MIN_P  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] MAX_P  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] INIT_P = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);
    localparam logic [POS_W:0]   MIN_X  = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]   MAX_X  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   STEP_X = (POS_W+1)'(STEP);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] timer;
    logic             dir_is_up;

    logic             dir_up;
    logic             dir_dn;
    logic             dir_any;
    logic [POS_W:0]   pos_x;
    logic [POS_W:0]   up_sum;
    logic [POS_W-1:0] up_pos;
    logic [POS_W-1:0] dn_pos;
    logic [POS_W-1:0] move_pos;
    logic             move_changes;

    // Pressing both buttons cancels out and behaves like a release
    assign dir_up  = btn_up & ~btn_down;
    assign dir_dn  = btn_down & ~btn_up;
    assign dir_any = dir_up | dir_dn;

    // Clamp in one extra bit so neither end can wrap around
    always_comb begin
        pos_x        = {1'b0, paddle_pos};
        up_sum       = pos_x + STEP_X;
        up_pos       = (up_sum > MAX_X) ? MAX_P : up_sum[POS_W-1:0];
        dn_pos       = (pos_x < MIN_X + STEP_X) ? MIN_P : paddle_pos - STEP_P;
        move_pos     = dir_up ? up_pos : dn_pos;
        move_changes = (move_pos != paddle_pos);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            paddle_pos <= INIT_P;
            move_pulse <= 1'b0;
            state      <= ST_IDLE;
            timer      <= '0;
            dir_is_up  <= 1'b0;
        end else if (center) begin
            paddle_pos <= INIT_P;
            move_pulse <= (paddle_pos != INIT_P);
            state      <= ST_IDLE;
            timer      <= '0;
        end else if (!enable) begin
            move_pulse <= 1'b0;
            state      <= ST_IDLE;
            timer      <= '0;
        end else begin
            move_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (dir_any) begin
                        paddle_pos <= move_pos;
                        move_pulse <= move_changes;
                        dir_is_up  <= dir_up;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!dir_any) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else if (dir_up != dir_is_up) begin
                        // A reversal is a fresh press: move now and restart the delay
                        paddle_pos <= move_pos;
                        move_pulse <= move_changes;
                        dir_is_up  <= dir_up;
                        state      <= ST_HOLD;
                        timer      <= '0;
                    end else if (timer == ((state == ST_HOLD) ? DELAY_LAST : RATE_LAST)) begin
                        paddle_pos <= move_pos;
                        move_pulse <= move_changes;
                        state      <= ST_REPEAT;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign at_top    = (paddle_pos == MAX_P);
    assign at_bottom = (paddle_pos == MIN_P);

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - directed self-checking bench for paddle_ctrl
module tb_paddle_ctrl;

    logic       clock;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       enable;
    logic       center;
    logic [9:0] paddle_pos;
    logic       move_pulse;
    logic       at_top;
    logic       at_bottom;

    int passed = 0;
    int total  = 0;

    paddle_ctrl #(
        .POS_W(10), .POS_MIN(0), .POS_MAX(20), .POS_INIT(10), .STEP(4),
        .CNT_W(25), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clock(clock), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .enable(enable), .center(center), .paddle_pos(paddle_pos),
        .move_pulse(move_pulse), .at_top(at_top), .at_bottom(at_bottom)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic recentre();
        btn_up = 0; btn_down = 0; center = 1;
        step();
        center = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 0; btn_up = 0; btn_down = 0; enable = 1; center = 0;
        step(); step();
        reset = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (paddle_pos !== 10'd10 || move_pulse !== 1'b0 || at_top !== 1'b0 || at_bottom !== 1'b0)
                $display("FAIL reset_idle cyc%0d: pos=%0d pulse=%b top=%b bot=%b, want 10 0 0 0",
                         i, paddle_pos, move_pulse, at_top, at_bottom);
            else passed++;
        end
        center = 1;
        step();
        center = 0;
        total++;
        if (paddle_pos !== 10'd10 || move_pulse !== 1'b0)
            $display("FAIL center_noop: pos=%0d pulse=%b, want 10 0", paddle_pos, move_pulse);
        else passed++;
    endtask

    task automatic test_single_press();
        btn_up = 1;
        step();
        total++;
        if (paddle_pos !== 10'd14 || move_pulse !== 1'b1)
            $display("FAIL single_move: pos=%0d pulse=%b, want 14 1", paddle_pos, move_pulse);
        else passed++;
        btn_up = 0;
        step();
        total++;
        if (paddle_pos !== 10'd14 || move_pulse !== 1'b0 || dut.state !== 2'd0)
            $display("FAIL single_release: pos=%0d pulse=%b state=%0d, want 14 0 0",
                     paddle_pos, move_pulse, dut.state);
        else passed++;
        recentre();
    endtask

    task automatic test_hold_repeat();
        logic [9:0] exp_pos [1:12];
        logic       exp_pls [1:12];
        exp_pos = '{10'd14, 10'd14, 10'd14, 10'd14, 10'd14, 10'd18,
                    10'd18, 10'd20, 10'd20, 10'd20, 10'd20, 10'd20};
        exp_pls = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        btn_up = 1;
        for (int c = 1; c <= 12; c++) begin
            step();
            total++;
            if (paddle_pos !== exp_pos[c] || move_pulse !== exp_pls[c])
                $display("FAIL hold_cyc%0d: pos=%0d pulse=%b, want %0d %b",
                         c, paddle_pos, move_pulse, exp_pos[c], exp_pls[c]);
            else passed++;
            if (c == 8) begin
                total++;
                if (at_top !== 1'b1)
                    $display("FAIL hold_at_top: at_top=%b, want 1", at_top);
                else passed++;
            end
        end
        recentre();
    endtask

    task automatic test_both_buttons();
        btn_down = 1;
        step();
        total++;
        if (paddle_pos !== 10'd6 || move_pulse !== 1'b1)
            $display("FAIL down_first: pos=%0d pulse=%b, want 6 1", paddle_pos, move_pulse);
        else passed++;
        btn_up = 1;
        step();
        total++;
        if (paddle_pos !== 10'd6 || move_pulse !== 1'b0 || dut.state !== 2'd0)
            $display("FAIL both_pressed: pos=%0d pulse=%b state=%0d, want 6 0 0",
                     paddle_pos, move_pulse, dut.state);
        else passed++;
        btn_up = 0;
        step();
        total++;
        if (paddle_pos !== 10'd2 || move_pulse !== 1'b1)
            $display("FAIL up_released: pos=%0d pulse=%b, want 2 1", paddle_pos, move_pulse);
        else passed++;
        for (int i = 0; i < 4; i++) step();
        step();
        total++;
        if (paddle_pos !== 10'd0 || move_pulse !== 1'b1 || at_bottom !== 1'b1)
            $display("FAIL clamp_bottom: pos=%0d pulse=%b bot=%b, want 0 1 1",
                     paddle_pos, move_pulse, at_bottom);
        else passed++;
        recentre();
    endtask

    task automatic test_center_mid_hold();
        btn_up = 1;
        step(); step(); step();
        total++;
        if (paddle_pos !== 10'd14)
            $display("FAIL center_pre: pos=%0d, want 14", paddle_pos);
        else passed++;
        center = 1;
        step();
        center = 0;
        total++;
        if (paddle_pos !== 10'd10 || move_pulse !== 1'b1)
            $display("FAIL center_reload: pos=%0d pulse=%b, want 10 1", paddle_pos, move_pulse);
        else passed++;
        step();
        total++;
        if (paddle_pos !== 10'd14 || move_pulse !== 1'b1)
            $display("FAIL center_repress: pos=%0d pulse=%b, want 14 1", paddle_pos, move_pulse);
        else passed++;
        recentre();
    endtask

    task automatic test_enable_and_reset();
        enable = 0; btn_down = 1;
        step(); step(); step();
        total++;
        if (paddle_pos !== 10'd10 || move_pulse !== 1'b0)
            $display("FAIL disabled_freeze: pos=%0d pulse=%b, want 10 0", paddle_pos, move_pulse);
        else passed++;
        enable = 1;
        step();
        total++;
        if (paddle_pos !== 10'd6 || move_pulse !== 1'b1)
            $display("FAIL enable_move: pos=%0d pulse=%b, want 6 1", paddle_pos, move_pulse);
        else passed++;
        for (int i = 0; i < 5; i++) step();
        step();
        total++;
        if (paddle_pos !== 10'd2 || dut.state !== 2'd2)
            $display("FAIL into_repeat: pos=%0d state=%0d, want 2 2", paddle_pos, dut.state);
        else passed++;
        #2 reset = 0;
        #1;
        total++;
        if (paddle_pos !== 10'd10 || move_pulse !== 1'b0 || dut.state !== 2'd0)
            $display("FAIL async_reset: pos=%0d pulse=%b state=%0d, want 10 0 0",
                     paddle_pos, move_pulse, dut.state);
        else passed++;
        step();
        btn_down = 0;
        reset = 1;
        step(); step();
        total++;
        if (paddle_pos !== 10'd10 || move_pulse !== 1'b0)
            $display("FAIL post_reset_idle: pos=%0d pulse=%b, want 10 0", paddle_pos, move_pulse);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_both_buttons();
        test_center_mid_hold();
        test_enable_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
